// File: rtl/accel_pkg.sv
// Shared formats for the float32 <-> Q2.22 converter.
package accel_pkg;

  localparam int unsigned FX_W      = 24;
  localparam int unsigned FX_FRAC   = 22;
  localparam int unsigned FT_W      = 32;
  localparam int unsigned FT_EXP_W  = 8;
  localparam int unsigned FT_MANT_W = 23;
  localparam int unsigned FT_BIAS   = 127;

  localparam logic [FX_W-1:0] FX_MAX = 24'h7FFFFF;
  localparam logic [FX_W-1:0] FX_MIN = 24'h800000;

  typedef logic signed [FX_W-1:0] fx_t;

  typedef struct packed {
    logic                 sign;
    logic [FT_EXP_W-1:0]  exp;
    logic [FT_MANT_W-1:0] mant;
  } ft_t;

endpackage

// File: rtl/accel_lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input reports 24.
module accel_lzc24
  import accel_pkg::*;
(
  input  logic [FX_W-1:0] d_i,
  output logic [4:0]      cnt_o,
  output logic            zero_o
);

  logic found;

  always_comb begin
    cnt_o = 5'd24;
    found = 1'b0;
    for (int unsigned i = 0; i < FX_W; i++) begin
      if (!found && d_i[FX_W-1-i]) begin
        cnt_o = 5'(i);
        found = 1'b1;
      end
    end
  end

  assign zero_o = ~|d_i;

endmodule

// File: rtl/accel_top.sv
// float32 -> Q2.22 and Q2.22 -> float32 converters, registered behind clk_en.
// ACCEL_ROUND_NEAREST_EN selects round-to-nearest-even for float->fixed (default truncates).
module accel_top
  import accel_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [FT_W-1:0]   x_ft,
  input  logic [FX_W-1:0]   x_fx,
  output logic [FX_W-1:0]   y_fx,
  output logic [FT_W-1:0]   y_ft
);

  ft_t         f_in;
  logic [23:0] sig;
  logic [7:0]  rsh;
  logic [4:0]  rsh_c;
  logic [24:0] mag;
  fx_t         y_fx_d, y_fx_q;
  ft_t         y_ft_d, y_ft_q;

  assign f_in = x_ft;
  assign sig  = {1'b1, f_in.mant};

  // Fixed magnitude = sig * 2^(exp-128); only exp < 128 reaches here unsaturated.
  // Shifts beyond 26 leave nothing at or above the half-LSB, so clamp there.
  assign rsh   = 8'd128 - f_in.exp;
  assign rsh_c = (rsh > 8'd26) ? 5'd26 : rsh[4:0];

`ifdef ACCEL_ROUND_NEAREST_EN
  logic [49:0] wide;
  logic        rnd_up;
  assign wide   = {sig, 26'b0} >> rsh_c;
  assign rnd_up = wide[25] & ((|wide[24:0]) | wide[26]);
  assign mag    = {1'b0, wide[49:26]} + {24'b0, rnd_up};
`else
  assign mag    = {1'b0, sig >> rsh_c};
`endif

  always_comb begin
    y_fx_d = '0;
    if (f_in.exp == '1)
      y_fx_d = (f_in.mant != '0) ? '0 : (f_in.sign ? FX_MIN : FX_MAX);
    else if (f_in.exp == '0)
      y_fx_d = '0;
    else if (f_in.exp[7])
      y_fx_d = f_in.sign ? FX_MIN : FX_MAX;
    else if (!f_in.sign)
      y_fx_d = (mag > 25'(FX_MAX)) ? FX_MAX : mag[23:0];
    else
      y_fx_d = (mag >= 25'(FX_MIN)) ? FX_MIN : -mag[23:0];
  end

  logic [FX_W-1:0]      fx_mag;
  logic [4:0]           lz;
  logic                 fx_zero;
  logic [FT_MANT_W-1:0] norm_mant;

  // 0x800000 negates to itself, which read unsigned is the required 2^23.
  assign fx_mag = x_fx[FX_W-1] ? -x_fx : x_fx;

  accel_lzc24 u_lzc (
    .d_i    (fx_mag),
    .cnt_o  (lz),
    .zero_o (fx_zero)
  );

  assign norm_mant = FT_MANT_W'(fx_mag << lz);

  always_comb begin
    y_ft_d = '0;
    if (!fx_zero) begin
      y_ft_d.sign = x_fx[FX_W-1];
      y_ft_d.exp  = 8'(FT_BIAS + FX_W - 1 - FX_FRAC) - {3'b0, lz};
      y_ft_d.mant = norm_mant;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_fx_q <= '0;
      y_ft_q <= '0;
    end else if (clk_en) begin
      y_fx_q <= y_fx_d;
      y_ft_q <= y_ft_d;
    end
  end

  assign y_fx = y_fx_q;
  assign y_ft = y_ft_q;

endmodule

// File: tb/tb_accel_top.sv
// Self-checking bench for accel_top: real-arithmetic reference model plus literal vectors.
module tb_accel_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic [31:0] x_ft;
  logic [23:0] x_fx;
  logic [23:0] y_fx;
  logic [31:0] y_ft;

  int   total = 0;
  int   bad   = 0;
  logic checking = 1'b0;
  logic [23:0] exp_fx;
  logic [31:0] exp_ft;

  accel_top dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .x_ft   (x_ft),
    .x_fx   (x_fx),
    .y_fx   (y_fx),
    .y_ft   (y_ft)
  );

  always #5 clk = ~clk;

`ifdef ACCEL_ROUND_NEAREST_EN
  localparam logic [23:0] RND15 = 24'h000002;
`else
  localparam logic [23:0] RND15 = 24'h000001;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Reference float32 -> Q2.22 from the real value of the operand.
  function automatic logic [23:0] fx_model(input logic [31:0] b);
    int    e;
    real   mag, ip;
    longint n;
`ifdef ACCEL_ROUND_NEAREST_EN
    real   fr;
`endif
    e = int'(b[30:23]);
    if (e == 255) return (b[22:0] != 23'd0) ? 24'h000000 : (b[31] ? 24'h800000 : 24'h7FFFFF);
    if (e == 0) return 24'h000000;
    mag = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (real'(e) - 127.0)) * 4194304.0;
    if (mag >= 16777216.0) begin
      n = 64'd16777216;
    end else begin
      ip = $floor(mag);
      n  = longint'($rtoi(ip));
`ifdef ACCEL_ROUND_NEAREST_EN
      fr = mag - ip;
      if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
`endif
    end
    if (!b[31]) return (n > 8388607) ? 24'h7FFFFF : 24'(n);
    return (n >= 8388608) ? 24'h800000 : 24'(-n);
  endfunction

  // Reference Q2.22 -> float32 by normalising the real magnitude into [1,2).
  function automatic logic [31:0] ft_model(input logic [23:0] x);
    logic   s;
    longint mi;
    real    m;
    int     e;
    int     mant;
    if (x == 24'd0) return 32'h0;
    s  = x[23];
    mi = s ? (64'd16777216 - {40'b0, x}) : {40'b0, x};
    m  = real'(mi) / 4194304.0;
    e  = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    mant = $rtoi((m - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(mant)};
  endfunction

  function automatic logic [31:0] rand_ft();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0: r = $urandom;
      1: r = {1'($urandom), 8'($urandom_range(96, 129)), 23'($urandom)};
      2: r = {1'($urandom), 8'($urandom_range(100, 127)), 3'($urandom), 20'b0};
      default: begin
        case ($urandom_range(0, 5))
          0: r = 32'h7F800000;
          1: r = 32'hFF800000;
          2: r = {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
          3: r = {1'($urandom), 8'h00, 23'($urandom)};
          4: r = {1'($urandom), 8'd128, 23'($urandom)};
          default: r = {1'($urandom), 8'd127, 23'($urandom)};
        endcase
      end
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_fx = 24'h0;
      exp_ft = 32'h0;
    end else if (clk_en) begin
      exp_fx = fx_model(x_ft);
      exp_ft = ft_model(x_fx);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_y_fx", {8'b0, y_fx}, {8'b0, exp_fx});
      chk("cyc_y_ft", y_ft, exp_ft);
    end
  end

  task automatic step(input logic [31:0] ft, input logic [23:0] fx, input logic en);
    @(negedge clk);
    #1;
    x_ft   = ft;
    x_fx   = fx;
    clk_en = en;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ft_in  [8] = '{32'h3F400000, 32'hBE800000, 32'h40400000, 32'hC0000000,
                              32'hFF800000, 32'h7FC00000, 32'h34C00000, 32'h34000000};
  logic [23:0] fx_in  [8] = '{24'h300000, 24'hD00000, 24'h066666, 24'h800000,
                              24'h000000, 24'h7FFFFF, 24'h000001, 24'hFFFFFF};
  logic [31:0] ft_exp [8] = '{32'h3F400000, 32'hBF400000, 32'h3DCCCCC0, 32'hC0000000,
                              32'h00000000, 32'h3FFFFFFE, 32'h34800000, 32'hB4800000};

  initial begin
    logic [23:0] fx_want [8];
    logic [23:0] v;
    logic [31:0] f;
    fx_want = '{24'h300000, 24'hF00000, 24'h7FFFFF, 24'h800000,
                24'h800000, 24'h000000, RND15, 24'h000000};

    reset = 1'b1; clk_en = 1'b0; x_ft = '0; x_fx = '0;
    #2;
    chk("reset_y_fx", {8'b0, y_fx}, 32'h0);
    chk("reset_y_ft", y_ft, 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    checking = 1'b1;

    chk("model_fx_0p75",  {8'b0, fx_model(32'h3F400000)}, 32'h300000);
    chk("model_fx_m0p25", {8'b0, fx_model(32'hBE800000)}, 32'hF00000);
    chk("model_fx_1p5lsb", {8'b0, fx_model(32'h34C00000)}, {8'b0, RND15});
    chk("model_fx_3p0",   {8'b0, fx_model(32'h40400000)}, 32'h7FFFFF);
    chk("model_ft_0p1",   ft_model(24'h066666), 32'h3DCCCCC0);
    chk("model_ft_m2",    ft_model(24'h800000), 32'hC0000000);

    for (int i = 0; i < 8; i++) begin
      step(ft_in[i], fx_in[i], 1'b1);
      chk($sformatf("vec%0d_y_fx", i), {8'b0, y_fx}, {8'b0, fx_want[i]});
      chk($sformatf("vec%0d_y_ft", i), y_ft, ft_exp[i]);
    end

    step(32'h3F400000, 24'h300000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step($urandom, 24'($urandom), 1'b0);
      chk("hold_y_fx", {8'b0, y_fx}, 32'h300000);
      chk("hold_y_ft", y_ft, 32'h3F400000);
    end
    step(32'hBE800000, 24'hD00000, 1'b1);
    chk("reload_y_fx", {8'b0, y_fx}, 32'hF00000);
    chk("reload_y_ft", y_ft, 32'hBF400000);

    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_y_fx", {8'b0, y_fx}, 32'h0);
    chk("async_rst_y_ft", y_ft, 32'h0);
    clk_en = 1'b1; x_ft = 32'h3F400000; x_fx = 24'h300000;
    @(posedge clk);
    #1;
    chk("rst_held_y_fx", {8'b0, y_fx}, 32'h0);
    chk("rst_held_y_ft", y_ft, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(32'h3F400000, 24'h300000, 1'b1);
    chk("post_rst_y_fx", {8'b0, y_fx}, 32'h300000);
    chk("post_rst_y_ft", y_ft, 32'h3F400000);

    for (int i = 0; i < 2000; i++)
      step(rand_ft(), 24'($urandom), 1'($urandom_range(0, 9) != 0));

    for (int i = 0; i < 300; i++) begin
      case (i)
        0: v = 24'h800000;
        1: v = 24'h7FFFFF;
        2: v = 24'h000001;
        3: v = 24'hFFFFFF;
        default: v = 24'($urandom);
      endcase
      step($urandom, v, 1'b1);
      f = y_ft;
      step(f, 24'($urandom), 1'b1);
      chk("roundtrip", {8'b0, y_fx}, {8'b0, v});
    end

    @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
